// File: rtl/mux_stim_sequencer_pkg.sv
// Shared types and constants for the mux stimulus sequencer.
// Optional MISR signature logic is enabled by MUX_STIM_SEQUENCER_MISR_EN.
package mux_stim_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } state_t;

  // x^8 + x^4 + x^3 + x^2 + 1 with the implicit x^8 term dropped
  localparam logic [7:0] MISR_POLY = 8'h1D;
  localparam logic [7:0] MISR_SEED = 8'hFF;

  // Bits needed to hold a count from 0 to n inclusive
  function automatic int unsigned counter_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mux_stim_sequencer_misr.sv
// 8-bit multiple-input signature register compressing the captured y stream.
// Only instantiated when MUX_STIM_SEQUENCER_MISR_EN is defined.
module mux_stim_misr
  import mux_stim_pkg::*;
(
  input  logic       clk,
  input  logic       load_seed,
  input  logic       en,
  input  logic       y_i,
  output logic [7:0] misr_o
);

  logic [7:0] feedback;

  // Polynomial feedback applied when the bit shifted out of the top is set
  always_comb begin
    feedback = misr_o[7] ? MISR_POLY : '0;
  end

  // Seed load has priority over a shift; the new y bit enters at bit 0
  always_ff @(posedge clk) begin
    if (load_seed) begin
      misr_o <= MISR_SEED;
    end else if (en) begin
      misr_o <= {misr_o[6:0], 1'b0} ^ feedback ^ {7'b0, y_i};
    end
  end

endmodule

// File: rtl/mux_stim_sequencer.sv
// Stimulus sequencer and response capture for the 3-input mux block.
// Drives a/b/c with k, k-1, k+1 (mod 2^WIDTH) for k = 1..ITERATIONS and
// captures the returned y bit one cycle after each vector is applied.
// Define MUX_STIM_SEQUENCER_MISR_EN to enable the 8-bit MISR on misr_o;
// otherwise misr_o is tied to zero.
module mux_stim_sequencer
  import mux_stim_pkg::*;
#(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned ITERATIONS = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 y_i,
  output logic [WIDTH-1:0]                     a_o,
  output logic [WIDTH-1:0]                     b_o,
  output logic [WIDTH-1:0]                     c_o,
  output logic                                 valid_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [ITERATIONS-1:0]                sig_o,
  output logic [counter_width(ITERATIONS)-1:0] ones_o,
  output logic [7:0]                           misr_o
);

  localparam int unsigned KW = counter_width(ITERATIONS);
  localparam int unsigned OW = counter_width(ITERATIONS);

  state_t          state;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_next;
  logic [WIDTH-1:0] a_next;
  logic [ITERATIONS-1:0] y_bit;

  // Next iteration index, next operand a, and the capture bit placed at k-1
  always_comb begin
    k_next = k + KW'(1);
    a_next = a_o + WIDTH'(1);
    y_bit  = ITERATIONS'(y_i) << (k - KW'(1));
  end

  // Control FSM with registered outputs.
  // The vector is derived from the current a_o rather than from k: a_o
  // already holds k mod 2^WIDTH (0 in INIT), so next a is a_o+1, next b
  // is the current a_o and next c is a_o+2, all wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      a_o     <= '0;
      b_o     <= '0;
      c_o     <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sig_o   <= '0;
      ones_o  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= INIT;
            k       <= '0;
            a_o     <= '0;
            b_o     <= '0;
            c_o     <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
            sig_o   <= '0;
            ones_o  <= '0;
          end
        end
        INIT: begin
          state   <= RUN;
          k       <= k_next;
          a_o     <= a_next;
          b_o     <= a_o;
          c_o     <= a_next + WIDTH'(1);
          valid_o <= 1'b1;
        end
        RUN: begin
          sig_o  <= sig_o | y_bit;
          ones_o <= ones_o + OW'(y_i);
          if (k == KW'(ITERATIONS)) begin
            state   <= DONE;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            k   <= k_next;
            a_o <= a_next;
            b_o <= a_o;
            c_o <= a_next + WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MUX_STIM_SEQUENCER_MISR_EN
  logic misr_load;
  logic misr_en;

  // Seed on reset and on every run start; shift on each RUN capture edge
  always_comb begin
    misr_load = rst || (((state == IDLE) || (state == DONE)) && start);
    misr_en   = (state == RUN);
  end

  mux_stim_misr u_misr (
    .clk       (clk),
    .load_seed (misr_load),
    .en        (misr_en),
    .y_i       (y_i),
    .misr_o    (misr_o)
  );
`else
  assign misr_o = '0;
`endif

endmodule

// File: tb/tb_mux_stim_sequencer.sv
// Self-checking bench for mux_stim_sequencer (WIDTH=3, ITERATIONS=10).
module tb_mux_stim_sequencer;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned ITER  = 10;
  localparam int          M     = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             y_i;
  logic [WIDTH-1:0] a_o, b_o, c_o;
  logic             valid_o, busy_o, done_o;
  logic [ITER-1:0]  sig_o;
  logic [3:0]       ones_o;
  logic [7:0]       misr_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   y_mode;
  logic y_rand;

  mux_stim_sequencer #(.WIDTH(WIDTH), .ITERATIONS(ITER)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .y_i     (y_i),
    .a_o     (a_o),
    .b_o     (b_o),
    .c_o     (c_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sig_o   (sig_o),
    .ones_o  (ones_o),
    .misr_o  (misr_o)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational mux block: y source chosen per test
  always_comb begin
    case (y_mode)
      0:       y_i = a_o[0];
      1:       y_i = 1'b1;
      2:       y_i = 1'b0;
      default: y_i = y_rand;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One MISR step as polynomial division: multiply by x, reduce mod 0x11D, add y
  function automatic logic [7:0] misr_step(input logic [7:0] m, input logic y);
    logic [8:0] t;
    t = {m, 1'b0};
    if (t[8]) t = t ^ 9'h11D;
    return t[7:0] ^ {7'd0, y};
  endfunction

  function automatic logic [7:0] misr_exp(input logic [7:0] m);
`ifdef MUX_STIM_SEQUENCER_MISR_EN
    return m;
`else
    return 8'h00 & m;
`endif
  endfunction

  task automatic check_outs(input string tag, input int a, input int b, input int c,
                            input int v, input int bz, input int d,
                            input logic [ITER-1:0] s, input int o, input logic [7:0] m);
    check({tag, "/a"},     32'(a_o),     a);
    check({tag, "/b"},     32'(b_o),     b);
    check({tag, "/c"},     32'(c_o),     c);
    check({tag, "/valid"}, 32'(valid_o), v);
    check({tag, "/busy"},  32'(busy_o),  bz);
    check({tag, "/done"},  32'(done_o),  d);
    check({tag, "/sig"},   32'(sig_o),   32'(s));
    check({tag, "/ones"},  32'(ones_o),  o);
    check({tag, "/misr"},  32'(misr_o),  32'(misr_exp(m)));
  endtask

  // One run from IDLE/DONE; pulse_k re-asserts start during RUN, rst_k aborts
  task automatic do_run(input int mode, input int pulse_k, input int rst_k,
                        output logic [ITER-1:0] sig_e, output int ones_e);
    logic [7:0] m;
    int busy_cnt;
    int ya;
    m        = 8'hFF;
    busy_cnt = 0;
    sig_e    = '0;
    ones_e   = 0;
    y_mode   = mode;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_outs("init", 0, 0, 0, 0, 1, 0, '0, 0, m);
    busy_cnt += int'(busy_o);
    for (int k = 1; k <= ITER; k++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      y_rand = 1'($urandom_range(0, 1));
      check_outs("run", k % M, (k + M - 1) % M, (k + 1) % M, 1, 1, 0, sig_e, ones_e, m);
      busy_cnt += int'(busy_o);
      if (k == rst_k) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_outs("rst_mid", 0, 0, 0, 0, 0, 0, '0, 0, 8'hFF);
        return;
      end
      case (mode)
        0:       ya = (k % M) % 2;
        1:       ya = 1;
        2:       ya = 0;
        default: ya = int'(y_rand);
      endcase
      sig_e[k-1] = ya[0];
      ones_e += ya;
      m = misr_step(m, ya[0]);
      if (k == pulse_k) start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check_outs("done", ITER % M, (ITER + M - 1) % M, (ITER + 1) % M, 0, 0, 1, sig_e, ones_e, m);
    check("busy_cycles", busy_cnt, ITER + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [ITER-1:0] s;
    int o;
    rst    = 1'b1;
    start  = 1'b0;
    y_mode = 2;
    y_rand = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      check_outs("reset", 0, 0, 0, 0, 0, 0, '0, 0, 8'hFF);
    end
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check_outs("idle", 0, 0, 0, 0, 0, 0, '0, 0, 8'hFF);
    end

    // Nominal: y follows a[0]
    do_run(0, -1, -1, s, o);
    check("nominal_sig", 32'(sig_o), 32'h155);
    check("nominal_ones", 32'(ones_o), 5);

    // Restart from DONE with y=1: wrap vectors are checked inside the run
    do_run(1, -1, -1, s, o);
    check("ones_sig", 32'(sig_o), 32'h3FF);
    check("ones_ones", 32'(ones_o), 10);

    // y=0 with a start pulse at k=4 that must be ignored
    do_run(2, 4, -1, s, o);
    check("zero_ones", 32'(ones_o), 0);

    // Abort at k=5, stay idle, then a complete run
    do_run(3, -1, 5, s, o);
    repeat (2) begin
      @(posedge clk); #1;
      check_outs("post_rst", 0, 0, 0, 0, 0, 0, '0, 0, 8'hFF);
    end
    do_run(0, -1, -1, s, o);
    check("rerun_sig", 32'(sig_o), 32'h155);

    // rst and start together: rst wins
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    check_outs("rst_start", 0, 0, 0, 0, 0, 0, '0, 0, 8'hFF);
    @(posedge clk); #1;
    check_outs("rst_start_idle", 0, 0, 0, 0, 0, 0, '0, 0, 8'hFF);

    // Random y streams with a random ignored start pulse
    for (int r = 0; r < 4; r++) begin
      do_run(3, int'($urandom_range(1, ITER)), -1, s, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
